param_datapath: RTL and testbench

Parametrised successor of the phase-1 bus datapath: a WIDTH-bit register file of NREGS general registers plus HI, LO, PC, MDR, MAR, Y and a 2×WIDTH Z register.
- All registers share one encoded-select bus.
- The ALU adds iterative multi-cycle multiply and divide, sequenced by an internal FSM with a start/busy/done handshake.
- It sits between the control unit and the memory/I-O subsystem.

---
 rtl/param_datapath.sv | 232 +++++++++++++++++++++++
 tb/tb_param_datapath.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// Parametrised bus datapath: register file, shared encoded-select bus and an ALU
// with single-cycle ops plus iterative shift-add multiply and restoring divide.
module param_datapath #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREGS   = 16,
  parameter int unsigned R0_ZERO = 1,
  parameter int unsigned SELW    = $clog2(NREGS + 8)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREGS-1:0]   rin,
  input  logic               hi_in,
  input  logic               lo_in,
  input  logic               y_in,
  input  logic               mar_in,
  input  logic               pc_in,
  input  logic               inc_pc,
  input  logic               mdr_in,
  input  logic               read,
  input  logic [SELW-1:0]    bus_sel,
  input  logic [WIDTH-1:0]   mdata_in,
  input  logic [WIDTH-1:0]   inport_data,
  input  logic [WIDTH-1:0]   c_imm,
  input  logic [3:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               div0,
  output logic [WIDTH-1:0]   bus_out,
  output logic [WIDTH-1:0]   mar_out,
  output logic [WIDTH-1:0]   pc_out,
  output logic [WIDTH-1:0]   mdr_out
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned CNTW = SHW;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_NEG  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [WIDTH-1:0]   gpr_q [NREGS];
  logic [WIDTH-1:0]   hi_q, lo_q, y_q, mar_q, pc_q, mdr_q;
  logic [WIDTH-1:0]   zh_q, zl_q;

  state_t             state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               mul_q;
  logic               busy_q, done_q, div0_q;

  logic [WIDTH-1:0]   sc_zh_c, sc_zl_c;
  logic               sc_div0_c, multi_c;
  logic [WIDTH:0]     add_c, sub_c;
  logic [2*WIDTH-1:0] rot_r_c, rot_l_c;
  logic [SHW-1:0]     amt_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [WIDTH+1:0]   div_trial_c;
  logic [2*WIDTH-1:0] iter_c;
  logic [WIDTH-1:0]   pc_d;

  assign busy    = busy_q;
  assign done    = done_q;
  assign div0    = div0_q;
  assign mar_out = mar_q;
  assign pc_out  = pc_q;
  assign mdr_out = mdr_q;

  // Encoded bus source mux; R0 optionally reads as constant zero.
  always_comb begin
    bus_out = '0;
    if (32'(bus_sel) < NREGS) begin
      if (!(R0_ZERO != 0 && bus_sel == '0)) bus_out = gpr_q[bus_sel[IDXW-1:0]];
    end else begin
      case (32'(bus_sel) - NREGS)
        32'd0:   bus_out = hi_q;
        32'd1:   bus_out = lo_q;
        32'd2:   bus_out = zh_q;
        32'd3:   bus_out = zl_q;
        32'd4:   bus_out = pc_q;
        32'd5:   bus_out = mdr_q;
        32'd6:   bus_out = inport_data;
        32'd7:   bus_out = c_imm;
        default: bus_out = '0;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_in)       pc_d = bus_out;
    else if (inc_pc) pc_d = pc_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      mar_q <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rin[i]) gpr_q[i] <= bus_out;
      end
      if (hi_in)  hi_q  <= bus_out;
      if (lo_in)  lo_q  <= bus_out;
      if (y_in)   y_q   <= bus_out;
      if (mar_in) mar_q <= bus_out;
      if (mdr_in) mdr_q <= read ? mdata_in : bus_out;
      pc_q <= pc_d;
    end
  end

  // Single-cycle results with A = Y and B = bus; flags ops that need the iterator.
  always_comb begin
    sc_zh_c   = '0;
    sc_zl_c   = '0;
    sc_div0_c = 1'b0;
    multi_c   = 1'b0;
    amt_c     = bus_out[SHW-1:0];
    add_c     = {1'b0, y_q} + {1'b0, bus_out};
    sub_c     = {1'b0, y_q} - {1'b0, bus_out};
    rot_r_c   = {y_q, y_q} >> amt_c;
    rot_l_c   = {y_q, y_q} << amt_c;
    case (op)
      OP_ADD: begin
        sc_zl_c = add_c[WIDTH-1:0];
        sc_zh_c = WIDTH'(add_c[WIDTH]);
      end
      OP_SUB: begin
        sc_zl_c = sub_c[WIDTH-1:0];
        sc_zh_c = WIDTH'(sub_c[WIDTH]);
      end
      OP_AND:  sc_zl_c = y_q & bus_out;
      OP_OR:   sc_zl_c = y_q | bus_out;
      OP_SHR:  sc_zl_c = y_q >> amt_c;
      OP_SHL:  sc_zl_c = y_q << amt_c;
      OP_ROR:  sc_zl_c = rot_r_c[WIDTH-1:0];
      OP_ROL:  sc_zl_c = rot_l_c[2*WIDTH-1:WIDTH];
      OP_NEG:  sc_zl_c = (~bus_out) + WIDTH'(1);
      OP_NOT:  sc_zl_c = ~bus_out;
      OP_MULU: multi_c = 1'b1;
      OP_DIVU: begin
        if (bus_out == '0) begin
          sc_zl_c   = '1;
          sc_zh_c   = y_q;
          sc_div0_c = 1'b1;
        end else begin
          multi_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One iteration: prod_q holds {acc, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum_c   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    div_trial_c = {1'b0, prod_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    if (mul_q)
      iter_c = {mul_sum_c, prod_q[WIDTH-1:1]};
    else if (!div_trial_c[WIDTH+1])
      iter_c = {div_trial_c[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    else
      iter_c = {prod_q[2*WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      mul_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      zh_q    <= '0;
      zl_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div0_q <= sc_div0_c;
            if (multi_c) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              mul_q   <= (op == OP_MULU);
              prod_q  <= {{WIDTH{1'b0}}, (op == OP_MULU) ? bus_out : y_q};
              opnd_q  <= (op == OP_MULU) ? y_q : bus_out;
            end else begin
              zh_q   <= sc_zh_c;
              zl_q   <= sc_zl_c;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          prod_q <= iter_c;
          cnt_q  <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(WIDTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            zh_q    <= iter_c[2*WIDTH-1:WIDTH];
            zl_q    <= iter_c[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath: a 32-bit/16-reg instance for the full
// op set and register file, plus a 16-bit/8-reg instance for the multiplier.
module tb_param_datapath;

  localparam int unsigned W   = 32;
  localparam int unsigned N   = 16;
  localparam int unsigned SW  = $clog2(N + 8);
  localparam int unsigned W2  = 16;
  localparam int unsigned N2  = 8;
  localparam int unsigned SW2 = $clog2(N2 + 8);

  localparam logic [SW-1:0] S_HI  = SW'(N);
  localparam logic [SW-1:0] S_LO  = SW'(N + 1);
  localparam logic [SW-1:0] S_ZH  = SW'(N + 2);
  localparam logic [SW-1:0] S_ZL  = SW'(N + 3);
  localparam logic [SW-1:0] S_PC  = SW'(N + 4);
  localparam logic [SW-1:0] S_MDR = SW'(N + 5);
  localparam logic [SW-1:0] S_INP = SW'(N + 6);
  localparam logic [SW-1:0] S_IMM = SW'(N + 7);

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic [N-1:0]  rin;
  logic          hi_in, lo_in, y_in, mar_in, pc_in, inc_pc, mdr_in, read, start;
  logic [SW-1:0] bus_sel;
  logic [W-1:0]  mdata_in, inport_data, c_imm;
  logic [3:0]    op;
  logic          busy, done, div0;
  logic [W-1:0]  bus_out, mar_out, pc_out, mdr_out;

  logic [N2-1:0]  s_rin;
  logic           s_y_in, s_start;
  logic [SW2-1:0] s_bus_sel;
  logic [W2-1:0]  s_c_imm;
  logic [3:0]     s_op;
  logic           s_busy, s_done, s_div0;
  logic [W2-1:0]  s_bus_out, s_mar_out, s_pc_out, s_mdr_out;

  param_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1)) dut (
    .clk(clk), .clr(clr), .rin(rin), .hi_in(hi_in), .lo_in(lo_in), .y_in(y_in),
    .mar_in(mar_in), .pc_in(pc_in), .inc_pc(inc_pc), .mdr_in(mdr_in), .read(read),
    .bus_sel(bus_sel), .mdata_in(mdata_in), .inport_data(inport_data), .c_imm(c_imm),
    .op(op), .start(start), .busy(busy), .done(done), .div0(div0),
    .bus_out(bus_out), .mar_out(mar_out), .pc_out(pc_out), .mdr_out(mdr_out)
  );

  param_datapath #(.WIDTH(W2), .NREGS(N2), .R0_ZERO(1)) dut16 (
    .clk(clk), .clr(clr), .rin(s_rin), .hi_in(1'b0), .lo_in(1'b0), .y_in(s_y_in),
    .mar_in(1'b0), .pc_in(1'b0), .inc_pc(1'b0), .mdr_in(1'b0), .read(1'b0),
    .bus_sel(s_bus_sel), .mdata_in(16'h0), .inport_data(16'h0), .c_imm(s_c_imm),
    .op(s_op), .start(s_start), .busy(s_busy), .done(s_done), .div0(s_div0),
    .bus_out(s_bus_out), .mar_out(s_mar_out), .pc_out(s_pc_out), .mdr_out(s_mdr_out)
  );

  typedef struct {
    logic [W-1:0] zh;
    logic [W-1:0] zl;
    logic         d0;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk = 0;
  int           n_bad = 0;
  logic [W-1:0] last_zl = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] t;
    int          amt;
    e.zh = '0;
    e.zl = '0;
    e.d0 = 1'b0;
    amt  = int'(b[4:0]);
    case (o)
      4'd0: begin
        t    = {32'd0, a} + {32'd0, b};
        e.zl = t[31:0];
        e.zh = {31'd0, t[32]};
      end
      4'd1: begin
        e.zl = a - b;
        e.zh = {31'd0, (a < b)};
      end
      4'd2: e.zl = a & b;
      4'd3: e.zl = a | b;
      4'd4: e.zl = a >> amt;
      4'd5: e.zl = a << amt;
      4'd6: e.zl = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
      4'd7: e.zl = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
      4'd8: e.zl = 32'd0 - b;
      4'd9: e.zl = ~b;
      4'd10: begin
        t    = {32'd0, a} * {32'd0, b};
        e.zh = t[63:32];
        e.zl = t[31:0];
      end
      4'd11: begin
        if (b == 0) begin
          e.zl = '1;
          e.zh = a;
          e.d0 = 1'b1;
        end else begin
          e.zl = a / b;
          e.zh = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic set_y(input logic [W-1:0] v);
    c_imm   = v;
    bus_sel = S_IMM;
    y_in    = 1'b1;
    tick();
    y_in    = 1'b0;
  endtask

  // Drive one op, push its expectation, wait for done, then pop and compare Z.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] bsel, input bit pulse);
    int   cyc;
    int   busy_n;
    int   exp_cyc;
    exp_t e;
    exp_cyc = ((o == 4'd10) || (o == 4'd11 && b != 0)) ? int'(W) : 0;
    set_y(a);
    if (bsel == S_IMM) c_imm = b;
    bus_sel = bsel;
    op      = o;
    start   = 1'b1;
    sb_q.push_back(model(o, a, b));
    tick();
    start  = 1'b0;
    cyc    = 0;
    busy_n = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_n++;
      if (cyc == 1 && busy) begin
        bus_sel = S_ZL;
        #1;
        check_eq({tag, "_zhold"}, 64'(bus_out), 64'(last_zl));
      end
      start = pulse && busy && (cyc == 3 || cyc == 7);
      tick();
      cyc++;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      check_eq({tag, "_timeout"}, 64'(0), 64'(1));
      return;
    end
    check_eq({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, "_busycyc"}, 64'(busy_n), 64'(exp_cyc));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    bus_sel = S_ZL;
    #1;
    check_eq({tag, "_zl"}, 64'(bus_out), 64'(e.zl));
    bus_sel = S_ZH;
    #1;
    check_eq({tag, "_zh"}, 64'(bus_out), 64'(e.zh));
    check_eq({tag, "_div0"}, 64'(div0), 64'(e.d0));
    last_zl = e.zl;
    tick();
    check_eq({tag, "_donepulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn;
    int cyc;
    logic [3:0]   o;
    logic [W-1:0] a, b;

    clr = 1'b0;
    rin = '0; hi_in = 0; lo_in = 0; y_in = 0; mar_in = 0; pc_in = 0; inc_pc = 0;
    mdr_in = 0; read = 0; start = 0; bus_sel = '0; mdata_in = '0; inport_data = '0;
    c_imm = '0; op = '0;
    s_rin = '0; s_y_in = 0; s_start = 0; s_bus_sel = '0; s_c_imm = '0; s_op = '0;
    repeat (3) tick();

    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_div0", 64'(div0), 64'(0));
    check_eq("rst_pc", 64'(pc_out), 64'(0));
    check_eq("rst_mar", 64'(mar_out), 64'(0));
    check_eq("rst_mdr", 64'(mdr_out), 64'(0));
    bus_sel = S_ZL; #1;
    check_eq("rst_zl", 64'(bus_out), 64'(0));
    clr = 1'b1;
    tick();

    // Register file and bus sources
    c_imm = 32'hA5A5A5A5; bus_sel = S_IMM; rin = 16'h0009;
    tick();
    rin = '0;
    bus_sel = SW'(3); #1;
    check_eq("r3_read", 64'(bus_out), 64'h0000_0000_A5A5_A5A5);
    bus_sel = SW'(0); #1;
    check_eq("r0_zero", 64'(bus_out), 64'(0));
    c_imm = 32'h0000_1234; bus_sel = S_IMM; pc_in = 1; inc_pc = 1;
    tick();
    pc_in = 0;
    check_eq("pc_prio", 64'(pc_out), 64'h1234);
    tick();
    inc_pc = 0;
    bus_sel = S_PC; #1;
    check_eq("pc_inc", 64'(bus_out), 64'h1235);
    c_imm = 32'hFFFF_FFFF; bus_sel = S_IMM; pc_in = 1;
    tick();
    pc_in = 0; inc_pc = 1;
    tick();
    inc_pc = 0;
    check_eq("pc_wrap", 64'(pc_out), 64'(0));
    mdata_in = 32'hDEAD_BEEF; c_imm = 32'h1357_9BDF; bus_sel = S_IMM; read = 1; mdr_in = 1;
    tick();
    check_eq("mdr_read", 64'(mdr_out), 64'hDEAD_BEEF);
    read = 0;
    tick();
    mdr_in = 0;
    bus_sel = S_MDR; #1;
    check_eq("mdr_bus", 64'(bus_out), 64'h1357_9BDF);
    c_imm = 32'h0BAD_F00D; bus_sel = S_IMM; mar_in = 1; hi_in = 1;
    tick();
    mar_in = 0; hi_in = 0; c_imm = 32'h7777_0001; lo_in = 1;
    tick();
    lo_in = 0;
    check_eq("mar", 64'(mar_out), 64'h0BAD_F00D);
    bus_sel = S_HI; #1;
    check_eq("hi", 64'(bus_out), 64'h0BAD_F00D);
    bus_sel = S_LO; #1;
    check_eq("lo", 64'(bus_out), 64'h7777_0001);
    inport_data = 32'h2468_ACE0; bus_sel = S_INP; #1;
    check_eq("inport", 64'(bus_out), 64'h2468_ACE0);
    bus_sel = SW'(N + 9); #1;
    check_eq("sel_oob", 64'(bus_out), 64'(0));

    // Directed ALU cases
    c_imm = 32'd1; bus_sel = S_IMM; rin = 16'h0002;
    tick();
    rin = '0;
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, SW'(1), 1'b0);
    run_op("ror1", 4'd6, 32'h8000_0001, 32'd1, S_IMM, 1'b0);
    run_op("sub_borrow", 4'd1, 32'd3, 32'd5, S_IMM, 1'b0);
    run_op("rol31", 4'd7, 32'h8000_0003, 32'd31, S_IMM, 1'b0);
    run_op("mulu", 4'd10, 32'h0001_0000, 32'h0001_0000, S_IMM, 1'b1);
    run_op("divu", 4'd11, 32'd100, 32'd7, S_IMM, 1'b1);
    run_op("div0", 4'd11, 32'd5, 32'd0, S_IMM, 1'b0);
    run_op("div0_clr", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, S_IMM, 1'b0);
    run_op("mulu_max", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, S_IMM, 1'b0);
    run_op("divu_big", 4'd11, 32'hFFFF_FFFF, 32'h0000_0003, S_IMM, 1'b0);
    run_op("op14", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, S_IMM, 1'b0);

    // Random ops across the whole opcode space
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom();
      b = (i % 6 == 5) ? 32'($urandom_range(1, 300)) : $urandom();
      run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, S_IMM, 1'b0);
    end

    // Narrow instance: 16-bit multiply and c_imm select
    s_c_imm = 16'hFFFF; s_bus_sel = SW2'(N2 + 7); s_y_in = 1;
    tick();
    s_y_in = 0;
    check_eq("w16_imm", 64'(s_bus_out), 64'hFFFF);
    s_op = 4'd10; s_start = 1;
    tick();
    s_start = 0;
    cyc = 0;
    while (!s_done && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("w16_lat", 64'(cyc), 64'(16));
    s_bus_sel = SW2'(N2 + 3); #1;
    check_eq("w16_zl", 64'(s_bus_out), 64'h0001);
    s_bus_sel = SW2'(N2 + 2); #1;
    check_eq("w16_zh", 64'(s_bus_out), 64'hFFFE);

    // Reset in the middle of a multiply
    set_y(32'h0003_0007);
    c_imm = 32'h0005_000B; bus_sel = S_IMM; op = 4'd10; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    check_eq("rstmid_busy_pre", 64'(busy), 64'(1));
    #1 clr = 1'b0;
    #1;
    check_eq("rstmid_busy", 64'(busy), 64'(0));
    check_eq("rstmid_done", 64'(done), 64'(0));
    tick();
    clr = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    check_eq("rstmid_nodone", 64'(dn), 64'(0));
    bus_sel = S_ZL; #1;
    check_eq("rstmid_zl", 64'(bus_out), 64'(0));
    bus_sel = S_ZH; #1;
    check_eq("rstmid_zh", 64'(bus_out), 64'(0));
    check_eq("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
